// File: rtl/secded_top.sv
// secded_top: Hamming(16,11) SECDED decoder engine with an internal 256x8 data memory.
// After reset release it walks NWORDS received words, decodes each one, writes the
// 11 data bits plus a 2-bit error flag back to memory, then raises done.

// Byte-wide data memory: combinational read, synchronous write, never cleared.
module secded_dmem (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] core [0:255];

  // Synchronous byte write; contents survive reset so preloaded inputs are kept.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      core[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = core[raddr_i];

endmodule

module secded_top #(
  parameter int unsigned NWORDS   = 15,
  parameter int unsigned IN_BASE  = 30,
  parameter int unsigned OUT_BASE = 0
) (
  input  logic clk,
  input  logic reset,
  output logic done
);

  localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_LO,
    S_LD_HI,
    S_ST_LO,
    S_ST_HI,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    rlo_q;
  logic [7:0]    rhi_q;
  logic          done_q;

  // Decoder signals
  logic [15:0] r;
  logic [3:0]  syn;
  logic        par;
  logic [15:0] rc;
  logic [1:0]  flag;
  logic [10:0] data;
  logic [15:0] result;

  // Memory-side signals
  logic [7:0] idx8;
  logic [7:0] off;
  logic [7:0] raddr;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       we;

  assign r    = {rhi_q, rlo_q};
  assign idx8 = 8'(idx_q);
  assign off  = {idx8[6:0], 1'b0};

  assign raddr = 8'(IN_BASE)  + off + ((state_q == S_LD_HI) ? 8'd1 : 8'd0);
  assign waddr = 8'(OUT_BASE) + off + ((state_q == S_ST_HI) ? 8'd1 : 8'd0);
  assign we    = (state_q == S_ST_LO) || (state_q == S_ST_HI);
  assign wdata = (state_q == S_ST_HI) ? result[15:8] : result[7:0];
  assign done  = done_q;

  secded_dmem dm1 (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Syndrome/parity decode of the captured word, single-bit correction and output packing.
  always_comb begin
    syn = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (r[4'(k)]) begin
        syn = syn ^ 4'(k);
      end
    end
    par = ^r;
    rc  = r;
    // Odd overall parity means one flipped bit at position syn (syn==0 is p0 itself).
    if (par) begin
      rc[syn] = ~r[syn];
    end
    if (par) begin
      flag = 2'b01;
    end else if (syn != '0) begin
      flag = 2'b10;
    end else begin
      flag = 2'b00;
    end
    data   = {rc[15:9], rc[7:5], rc[3]};
    result = {flag, 3'b000, data};
  end

  // Sequencer: four cycles per word (load low, load high, store low, store high), then done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rlo_q   <= '0;
      rhi_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_LD_LO;
        end
        S_LD_LO: begin
          rlo_q   <= rdata;
          state_q <= S_LD_HI;
        end
        S_LD_HI: begin
          rhi_q   <= rdata;
          state_q <= S_ST_LO;
        end
        S_ST_LO: begin
          state_q <= S_ST_HI;
        end
        S_ST_HI: begin
          if (idx_q == IW'(NWORDS - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= S_LD_LO;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secded_top.sv
// tb_secded_top: directed-vector bench for secded_top with hand-computed expected results.
module tb_secded_top;

  localparam int NW      = 15;
  localparam int IN_BASE = 30;

  logic clk;
  logic reset;
  logic done;

  int n_checks;
  int n_errors;

  logic [15:0] rx [0:NW-1];
  logic [15:0] ex [0:NW-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  secded_top dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_inputs();
    for (int i = 0; i < NW; i++) begin
      dut.dm1.core[IN_BASE + 2*i]     = rx[i][7:0];
      dut.dm1.core[IN_BASE + 2*i + 1] = rx[i][15:8];
    end
  endtask

  task automatic fill_outputs(input logic [7:0] v);
    for (int i = 0; i < 2*NW; i++) begin
      dut.dm1.core[i] = v;
    end
  endtask

  function automatic logic [15:0] get_result(input int i);
    return {dut.dm1.core[2*i + 1], dut.dm1.core[2*i]};
  endfunction

  // Data bits pulled straight from a codeword by the bit map (no correction).
  function automatic logic [10:0] extract(input logic [15:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

  // Counts rising edges until done is seen, bounded.
  task automatic run_to_done(output int edges);
    edges = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic check_results(input string pfx);
    for (int i = 0; i < NW; i++) begin
      check($sformatf("%s_w%0d", pfx, i), get_result(i), ex[i]);
    end
  endtask

  task automatic set_run1_table();
    // 0xB42D encodes data 0x5A3 (p0=1, p2=1); 0xFFFF encodes 0x7FF.
    rx[0] = 16'hB42D; ex[0] = 16'h05A3;  // clean
    rx[1] = 16'hB46D; ex[1] = 16'h45A3;  // r[6] flipped
    rx[2] = 16'hB42C; ex[2] = 16'h45A3;  // p0 flipped
    rx[3] = 16'h0000; ex[3] = 16'h0000;  // all-zero codeword
    rx[4] = 16'hFFFF; ex[4] = 16'h07FF;  // all-ones codeword
    rx[5] = 16'hEFFF; ex[5] = 16'h47FF;  // r[12] flipped
    rx[6] = 16'h0200; ex[6] = 16'h4000;  // r[9] flipped on zero word
    rx[7] = 16'hFFF9; ex[7] = 16'h87FF;  // r[1], r[2] flipped: double
    for (int i = 8; i < NW; i++) begin
      rx[i] = 16'hB42D; ex[i] = 16'h05A3;
    end
  endtask

  int edges;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;

    // Run 1: mixed clean / single / double-error words
    set_run1_table();
    load_inputs();
    fill_outputs(8'hEE);
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 16'(done), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    run_to_done(edges);
    check("run1_latency", 16'(edges), 16'd61);
    check("run1_done", 16'(done), 16'h0001);
    check_results("run1");

    // Hold after done: no further writes, done stays high
    repeat (50) @(posedge clk);
    #1;
    check("hold_done", 16'(done), 16'h0001);
    check_results("hold");

    // Run 2: word i has bits i and i+1 flipped -> double error on every word
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst2_done", 16'(done), 16'h0000);
    for (int i = 0; i < NW; i++) begin
      rx[i] = 16'hB42D ^ (16'h0003 << i);
      ex[i] = {2'b10, 3'b000, extract(rx[i])};
    end
    load_inputs();
    @(negedge clk);
    reset = 1'b1;
    run_to_done(edges);
    check("run2_latency", 16'(edges), 16'd61);
    check_results("run2");
    for (int i = 0; i < NW; i++) begin
      check($sformatf("run2_f_w%0d", i), 16'(dut.dm1.core[2*i + 1][7:6]), 16'h0002);
    end

    // Run 3: abort at cycle 20, then full rerun
    @(negedge clk);
    reset = 1'b0;
    set_run1_table();
    load_inputs();
    fill_outputs(8'hEE);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_done", 16'(done), 16'h0000);
    check("abort_w3", get_result(3), ex[3]);
    check("abort_w4", get_result(4), {8'hEE, ex[4][7:0]});
    check("abort_w5", get_result(5), 16'hEEEE);
    repeat (3) @(posedge clk);
    #1;
    check("abort_hold_done", 16'(done), 16'h0000);
    check("abort_hold_w5", get_result(5), 16'hEEEE);
    @(negedge clk);
    reset = 1'b1;
    run_to_done(edges);
    check("run3_latency", 16'(edges), 16'd61);
    check("run3_done", 16'(done), 16'h0001);
    check_results("run3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
